// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word over Avalon-MM and plays it out as two 16-bit audio samples,
// one per sample_tick, then pulses finish (with error on a read timeout) back to the address stage.
module flash_sample_reader #(
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int SAMPLE_W    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   address,
    input  logic                forward,
    input  logic                sample_tick,
    output logic                flash_mem_read,
    output logic [ADDR_W-1:0]   flash_mem_address,
    output logic [3:0]          flash_mem_byteenable,
    input  logic                flash_mem_waitrequest,
    input  logic [DATA_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_data,
    output logic                audio_valid,
    output logic                finish,
    output logic                error,
    output logic                busy,
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        WAIT_VALID = 3'd2,
        WAIT_T0    = 3'd3,
        WAIT_T1    = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   word_q;
    logic                dir_q;
    logic                pending;
    logic                err_q;
    logic                timeout;
    logic                take;
    logic [SAMPLE_W-1:0] half_lo, half_hi;

    // Avalon read: a request is accepted on any cycle where read=1 and waitrequest=0;
    // data arrives later on the single cycle readdatavalid=1, which is honoured only in WAIT_VALID.
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign take    = sample_tick | pending;
    assign half_lo = word_q[SAMPLE_W-1:0];
    assign half_hi = word_q[DATA_W-1:SAMPLE_W];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start) state_next = REQ;
            REQ: begin
                if (!flash_mem_waitrequest) state_next = WAIT_VALID;
                else if (timeout)           state_next = DONE;
            end
            WAIT_VALID: begin
                if (flash_mem_readdatavalid) state_next = WAIT_T0;
                else if (timeout)            state_next = DONE;
            end
            WAIT_T0:    if (take) state_next = WAIT_T1;
            WAIT_T1:    if (take) state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        flash_mem_read       = (state == REQ);
        flash_mem_byteenable = 4'b1111;
        busy                 = (state != IDLE);
        finish               = (state == DONE);
        error                = (state == DONE) && err_q;
        state_dbg            = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flash_mem_address <= '0;
            word_q            <= '0;
            dir_q             <= 1'b0;
            cnt               <= '0;
            err_q             <= 1'b0;
            audio_data        <= '0;
            audio_valid       <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        flash_mem_address <= address;
                        dir_q             <= forward;
                        cnt               <= '0;
                        err_q             <= 1'b0;
                    end
                end
                REQ, WAIT_VALID: begin
                    cnt   <= cnt + 1'b1;
                    err_q <= (state_next == DONE);
                    if (state == WAIT_VALID && flash_mem_readdatavalid) word_q <= flash_mem_readdata;
                end
                WAIT_T0: begin
                    if (take) begin
                        audio_data  <= dir_q ? half_lo : half_hi;
                        audio_valid <= 1'b1;
                    end
                end
                WAIT_T1: begin
                    if (take) begin
                        audio_data  <= dir_q ? half_hi : half_lo;
                        audio_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-deep memory of a tick that arrives while no sample can be emitted yet.
    always_ff @(posedge clk) begin
        if (rst || state_next == IDLE)
            pending <= 1'b0;
        else if (sample_tick && (state == REQ || state == WAIT_VALID || state == DONE))
            pending <= 1'b1;
        else if (state == WAIT_T0 && take)
            pending <= 1'b0;
    end

endmodule
